// File: rtl/decchk1_pkg.sv
// rtl/decchk1_pkg.sv - shared constants and popcount helpers for the ONES-out-of-WIDTH checker
// Contents:
//   ONES_DEFAULT, WIDTH_DEFAULT : default checker parameters
//   POP_MAX                     : widest code word the popcount helper accepts
//   count_width(w)              : bits needed to hold a count of 0..w without overflow
//   popcount(v)                 : number of set bits in v, every bit weighted equally
package decchk1_pkg;

  localparam int ONES_DEFAULT  = 2;
  localparam int WIDTH_DEFAULT = 5;
  localparam int POP_MAX       = 64;

  function automatic int count_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

  function automatic int popcount(input logic [POP_MAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/decchk_popcount.sv
// rtl/decchk_popcount.sv - combinational population count of a WIDTH-bit vector
// Ports:
//   value : input  [WIDTH-1:0]   vector to count
//   count : output [COUNT_W-1:0] number of set bits in value
module decchk_popcount
  import decchk1_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int COUNT_W = count_width(WIDTH)
) (
  input  logic [WIDTH-1:0]   value,
  output logic [COUNT_W-1:0] count
);

  // Zero-extend into the helper's fixed width; the extra bits add nothing.
  // COUNT_W holds 0..WIDTH, so the truncating cast never loses a count.
  always_comb begin
    count = COUNT_W'(popcount(POP_MAX'(value)));
  end

endmodule

// File: rtl/decchk1.sv
// rtl/decchk1.sv - registered ONES-out-of-WIDTH code word validity check
// Ports:
//   i_clk   : input            clock, all state on rising edge
//   i_reset : input            synchronous active-high reset, clears o_check
//   i_value : input [WIDTH-1:0] code word, sampled every rising edge
//   o_check : output           1 when the word sampled at the previous edge had exactly ONES set bits
module decchk1
  import decchk1_pkg::*;
#(
  parameter int ONES  = ONES_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_check
);

  localparam int COUNT_W = count_width(WIDTH);

  logic [COUNT_W-1:0] count;
  logic               match;

  decchk_popcount #(
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W)
  ) u_popcount (
    .value (i_value),
    .count (count)
  );

  // Compare at integer width so ONES beyond the count range (ONES > WIDTH)
  // simply never matches instead of aliasing onto a truncated value.
  always_comb begin
    match = (int'(count) == ONES);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_check <= 1'b0;
    end else begin
      o_check <= match;
    end
  end

endmodule

// File: tb/tb_decchk1.sv
// tb/tb_decchk1.sv - self-checking bench for decchk1 (ONES=3 instance and default-parameter instance)
module tb_decchk1;

  logic       clk;
  logic       rst;
  logic [4:0] value;
  logic       check3;
  logic       check2;

  int checks;
  int errors;

  decchk1 #(.ONES(3), .WIDTH(5)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_value (value),
    .o_check (check3)
  );

  decchk1 dut_def (
    .i_clk   (clk),
    .i_reset (rst),
    .i_value (value),
    .o_check (check2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count bits arithmetically and compare with the required weight.
  function automatic logic model(input int v, input int ones, input logic r);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) n += (v >> i) & 1;
    return r ? 1'b0 : logic'(n == ones);
  endfunction

  function automatic logic listed(input int v, input int l[10]);
    for (int i = 0; i < 10; i++) if (l[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, let one rising edge sample them, then observe 1 time unit later.
  task automatic tick(input int v, input logic r);
    value = v[4:0];
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits3[10];
    int hits2[10];
    int n3;
    int n2;
    int v;
    logic r;

    hits3  = '{'h07, 'h0B, 'h0D, 'h0E, 'h13, 'h15, 'h16, 'h19, 'h1A, 'h1C};
    hits2  = '{'h03, 'h05, 'h06, 'h09, 'h0A, 'h0C, 'h11, 'h12, 'h14, 'h18};
    checks = 0;
    errors = 0;
    value  = 5'h00;
    rst    = 1'b1;

    // Reset held for two cycles with a valid word present
    tick('h07, 1'b1);
    chk("reset_cycle1", check3, 1'b0);
    chk("reset_cycle1_def", check2, 1'b0);
    tick('h07, 1'b1);
    chk("reset_cycle2", check3, 1'b0);
    tick('h07, 1'b0);
    chk("reset_release", check3, 1'b1);
    chk("reset_release_def", check2, 1'b0);

    // Full sweep, both parameterisations
    n3 = 0;
    n2 = 0;
    for (int i = 0; i < 32; i++) begin
      tick(i, 1'b0);
      chk($sformatf("sweep3_%02h", i), check3, listed(i, hits3));
      chk($sformatf("sweep2_%02h", i), check2, listed(i, hits2));
      n3 += int'(check3);
      n2 += int'(check2);
    end
    chk_int("sweep3_hits", n3, 10);
    chk_int("sweep2_hits", n2, 10);

    // Boundary words
    tick('h00, 1'b0); chk("bound_00", check3, 1'b0); chk("bound_00_def", check2, 1'b0);
    tick('h1F, 1'b0); chk("bound_1f", check3, 1'b0); chk("bound_1f_def", check2, 1'b0);
    tick('h0F, 1'b0); chk("bound_0f", check3, 1'b0);
    tick('h03, 1'b0); chk("bound_03", check3, 1'b0); chk("bound_03_def", check2, 1'b1);

    // Back-to-back transitions
    tick('h07, 1'b0); chk("b2b_07", check3, 1'b1);
    tick('h0F, 1'b0); chk("b2b_0f", check3, 1'b0);
    tick('h1C, 1'b0); chk("b2b_1c", check3, 1'b1);

    // Mid-stream reset pulse with a valid word held, then hold constant
    tick('h1C, 1'b1); chk("midreset_drop", check3, 1'b0);
    tick('h1C, 1'b0); chk("midreset_back", check3, 1'b1);
    tick('h1C, 1'b0); chk("hold_const", check3, 1'b1);

    // Randomized words with occasional reset, against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      v = int'($urandom_range(31, 0));
      r = ($urandom_range(7, 0) == 0);
      tick(v, r);
      chk($sformatf("rand3_%0d_%02h_r%0b", i, v, r), check3, model(v, 3, r));
      chk($sformatf("rand2_%0d_%02h_r%0b", i, v, r), check2, model(v, 2, r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decchk1.md
DECCHK1 -- requirements
Module: decchk1

Interface
REQ-001 Parameter ONES, default 2, is the exact number of set bits that makes a code word valid; it is the first positional parameter.
REQ-002 Parameter WIDTH, default 5, is the code word width in bits.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port i_value, input, WIDTH bits: code word to check; unregistered, sampled each rising edge.
REQ-006 Port o_check, output, 1 bit: registered validity flag for the word sampled at the previous rising edge.

Function
REQ-007 o_check SHALL be 1 when popcount(i_value) equals ONES exactly, else 0 (ONES-out-of-WIDTH check).
REQ-008 The population count SHALL be computed at a width of ceil(log2(WIDTH+1)) bits with no overflow; all WIDTH bits SHALL count equally, with no positional weighting.
REQ-009 Latency: o_check SHALL reflect the i_value sampled at rising edge n, valid after that edge and held until edge n+1.
REQ-010 With i_value held constant, o_check SHALL remain constant.
REQ-011 ONES=0 SHALL flag only the all-zero word; ONES=WIDTH SHALL flag only the all-ones word; ONES>WIDTH SHALL never assert o_check.
REQ-012 All-zero and all-ones words SHALL be invalid unless ONES equals 0 or WIDTH respectively.
REQ-013 X/Z on i_value is outside the defined behaviour; no X-propagation handling is required.
REQ-014 There SHALL be no other state; the block is a pure registered function of i_value.

Reset
REQ-015 While i_reset is 1 at a rising edge, o_check SHALL be 0 at the next cycle regardless of i_value.
REQ-016 At the first rising edge after i_reset deasserts, o_check SHALL load the check result for the current i_value, with no additional warm-up cycles.
REQ-017 Reset asserted mid-stream SHALL clear o_check at the next edge; no other state needs clearing.

Structure
REQ-018 A shared package SHALL hold a popcount function, the count-width helper, and the default constants ONES_DEFAULT=2 and WIDTH_DEFAULT=5.
REQ-019 One sub-module, decchk_popcount (combinational, parameter WIDTH, input vector, output count), is natural.
REQ-020 decchk1 SHALL instantiate decchk_popcount, compare its count with ONES, and register the result into o_check.

Verification (ONES=3, WIDTH=5 unless noted)
REQ-021 Hold i_reset=1 for 2 cycles with i_value=5'h07 -> o_check=0 throughout; after reset release, o_check=1 one cycle later.
REQ-022 Sweep i_value 0..31, one value per clock -> o_check=1 exactly for 07, 0B, 0D, 0E, 13, 15, 16, 19, 1A, 1C (10 hits), each one cycle after the value is applied.
REQ-023 Boundary words: 00 -> 0; 1F -> 0; 0F -> 0 (4 ones); 03 -> 0 (2 ones).
REQ-024 Back-to-back transitions 07 -> 0F -> 1C on consecutive cycles -> o_check 1, 0, 1 on the following consecutive cycles.
REQ-025 Assert i_reset for one cycle while i_value=1C is held -> o_check drops to 0 for one cycle, then returns to 1.
REQ-026 Default parameters (ONES=2, WIDTH=5), full sweep -> exactly 10 hits: 03, 05, 06, 09, 0A, 0C, 11, 12, 14, 18.
